// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light monitor: light codes, phase codes,
// error codes, default dwell lengths and the legal phase-successor table.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [2:0] PH_AG   = 3'd0;
  localparam logic [2:0] PH_AY   = 3'd1;
  localparam logic [2:0] PH_BG   = 3'd2;
  localparam logic [2:0] PH_BY   = 3'd3;
  localparam logic [2:0] PH_CG   = 3'd4;
  localparam logic [2:0] PH_CY   = 3'd5;
  localparam logic [2:0] PH_PED  = 3'd6;
  localparam logic [2:0] PH_NONE = 3'd7;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ENC      = 3'd1;
  localparam logic [2:0] ERR_CONFLICT = 3'd2;
  localparam logic [2:0] ERR_ORDER    = 3'd3;
  localparam logic [2:0] ERR_DWELL    = 3'd4;
  localparam logic [2:0] ERR_ALLRED   = 3'd5;

  localparam int unsigned GREEN_LEN_DEFAULT  = 11;
  localparam int unsigned YELLOW_LEN_DEFAULT = 4;
  localparam int unsigned PED_LEN_DEFAULT    = 6;

  function automatic logic is_green(input logic [2:0] ph);
    return (ph == PH_AG) || (ph == PH_BG) || (ph == PH_CG);
  endfunction

  function automatic logic is_yellow(input logic [2:0] ph);
    return (ph == PH_AY) || (ph == PH_BY) || (ph == PH_CY);
  endfunction

  // Yellow may go to PED only with a pending ped_req, and to green only without one.
  function automatic logic is_legal_next(input logic [2:0] prev, input logic [2:0] next,
                                         input logic ped_req_prev);
    logic legal;
    legal = 1'b0;
    case (prev)
      PH_AG:   legal = (next == PH_AY);
      PH_AY:   legal = ((next == PH_BG) && !ped_req_prev) || ((next == PH_PED) && ped_req_prev);
      PH_BG:   legal = (next == PH_BY);
      PH_BY:   legal = ((next == PH_CG) && !ped_req_prev) || ((next == PH_PED) && ped_req_prev);
      PH_CG:   legal = (next == PH_CY);
      PH_CY:   legal = ((next == PH_AG) && !ped_req_prev) || ((next == PH_PED) && ped_req_prev);
      PH_PED:  legal = (next == PH_BG);
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/traffic_phase_decode.sv
// Combinational decode of the observed lights and WALK signal into a phase,
// plus the per-sample ENC, CONFLICT and ALLRED flags.
module traffic_phase_decode
  import traffic_pkg::*;
(
  input  logic [2:0] light_a,
  input  logic [2:0] light_b,
  input  logic [2:0] light_c,
  input  logic       ped_signal,
  output logic [2:0] phase,
  output logic       enc_err,
  output logic       conflict_err,
  output logic       allred_err
);

  function automatic logic legal_light(input logic [2:0] l);
    return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
  endfunction

  logic a_go, b_go, c_go;

  assign a_go = (light_a != LIGHT_RED);
  assign b_go = (light_b != LIGHT_RED);
  assign c_go = (light_c != LIGHT_RED);

  always_comb begin
    enc_err      = !(legal_light(light_a) && legal_light(light_b) && legal_light(light_c));
    conflict_err = !enc_err && ((a_go && b_go) || (a_go && c_go) || (b_go && c_go) ||
                                (ped_signal && (a_go || b_go || c_go)));
    allred_err   = !enc_err && !a_go && !b_go && !c_go && !ped_signal;

    phase = PH_NONE;
    if (!enc_err && !conflict_err && !allred_err) begin
      if (a_go) begin
        phase = (light_a == LIGHT_GREEN) ? PH_AG : PH_AY;
      end else if (b_go) begin
        phase = (light_b == LIGHT_GREEN) ? PH_BG : PH_BY;
      end else if (c_go) begin
        phase = (light_c == LIGHT_GREEN) ? PH_CG : PH_CY;
      end else begin
        phase = PH_PED;
      end
    end
  end

endmodule

// File: rtl/traffic_monitor.sv
// Observes a three-road traffic light with pedestrian phase and reports
// encoding, conflict, ordering, dwell and all-red faults one cycle later.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_LEN  = GREEN_LEN_DEFAULT,
  parameter int unsigned YELLOW_LEN = YELLOW_LEN_DEFAULT,
  parameter int unsigned PED_LEN    = PED_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] lightA,
  input  logic [2:0] lightB,
  input  logic [2:0] lightC,
  input  logic       ped_signal,
  input  logic       emergency,
  input  logic       ped_req,
  output logic [2:0] cur_phase,
  output logic       err_valid,
  output logic [2:0] err_code,
  output logic       err_sticky,
  output logic [7:0] green_cnt_a,
  output logic [7:0] green_cnt_b,
  output logic [7:0] green_cnt_c,
  output logic [7:0] ped_cnt,
  output logic [7:0] err_cnt
);

  logic [2:0] dec_phase;
  logic       enc_err, conflict_err, allred_err;

  traffic_phase_decode u_decode (
    .light_a      (lightA),
    .light_b      (lightB),
    .light_c      (lightC),
    .ped_signal   (ped_signal),
    .phase        (dec_phase),
    .enc_err      (enc_err),
    .conflict_err (conflict_err),
    .allred_err   (allred_err)
  );

  logic [2:0] phase_q, phase_d;
  logic [4:0] dwell_q, dwell_d;
  logic       first_q, first_d;
  logic       emerg_seen_q, emerg_seen_d;
  logic       none_seen_q, none_seen_d;
  logic       emerg_prev_q, ped_req_prev_q;
  logic [2:0] err_code_d;
  logic       entry, fresh;

  function automatic logic [4:0] phase_len(input logic [2:0] ph);
    logic [4:0] len;
    if (is_green(ph)) begin
      len = 5'(GREEN_LEN);
    end else if (is_yellow(ph)) begin
      len = 5'(YELLOW_LEN);
    end else begin
      len = 5'(PED_LEN);
    end
    return len;
  endfunction

  // A fresh phase (after reset or a NONE sample) skips both order and dwell checks.
  assign fresh = none_seen_q || (phase_q == PH_NONE);

  always_comb begin
    phase_d      = phase_q;
    dwell_d      = dwell_q;
    first_d      = first_q;
    emerg_seen_d = emerg_seen_q;
    none_seen_d  = none_seen_q;
    err_code_d   = ERR_NONE;
    entry        = 1'b0;

    if (enc_err) begin
      err_code_d  = ERR_ENC;
      none_seen_d = 1'b1;
    end else if (conflict_err) begin
      err_code_d  = ERR_CONFLICT;
      none_seen_d = 1'b1;
    end else if (allred_err) begin
      err_code_d  = ERR_ALLRED;
      none_seen_d = 1'b1;
    end else if (fresh || (dec_phase != phase_q)) begin
      entry = 1'b1;
      if (!fresh) begin
        if (!(is_legal_next(phase_q, dec_phase, ped_req_prev_q) ||
              ((dec_phase == PH_AG) && emerg_prev_q))) begin
          err_code_d = ERR_ORDER;
        end else if (!first_q && !emerg_seen_q && !emergency && (dwell_q != 5'd31) &&
                     (dwell_q != phase_len(phase_q))) begin
          // A dwell that hit 31 was already reported as stuck (or was exempt).
          err_code_d = ERR_DWELL;
        end
      end
      phase_d      = dec_phase;
      dwell_d      = 5'd1;
      first_d      = fresh;
      emerg_seen_d = emergency;
      none_seen_d  = 1'b0;
    end else begin
      if (dwell_q != 5'd31) begin
        dwell_d = dwell_q + 5'd1;
      end
      emerg_seen_d = emerg_seen_q || emergency;
      if ((dwell_q == 5'd30) && !first_q && !emerg_seen_d) begin
        err_code_d = ERR_DWELL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q        <= PH_NONE;
      dwell_q        <= 5'd0;
      first_q        <= 1'b0;
      emerg_seen_q   <= 1'b0;
      none_seen_q    <= 1'b0;
      emerg_prev_q   <= 1'b0;
      ped_req_prev_q <= 1'b0;
      cur_phase      <= PH_NONE;
      err_valid      <= 1'b0;
      err_code       <= ERR_NONE;
      err_sticky     <= 1'b0;
      green_cnt_a    <= 8'd0;
      green_cnt_b    <= 8'd0;
      green_cnt_c    <= 8'd0;
      ped_cnt        <= 8'd0;
      err_cnt        <= 8'd0;
    end else begin
      phase_q        <= phase_d;
      dwell_q        <= dwell_d;
      first_q        <= first_d;
      emerg_seen_q   <= emerg_seen_d;
      none_seen_q    <= none_seen_d;
      emerg_prev_q   <= emergency;
      ped_req_prev_q <= ped_req;
      cur_phase      <= dec_phase;
      err_valid      <= (err_code_d != ERR_NONE);
      err_code       <= err_code_d;
      if (err_code_d != ERR_NONE) begin
        err_sticky <= 1'b1;
        if (err_cnt != 8'hff) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (entry && (dec_phase == PH_AG)) green_cnt_a <= green_cnt_a + 8'd1;
      if (entry && (dec_phase == PH_BG)) green_cnt_b <= green_cnt_b + 8'd1;
      if (entry && (dec_phase == PH_CG)) green_cnt_c <= green_cnt_c + 8'd1;
      if (entry && (dec_phase == PH_PED)) ped_cnt <= ped_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed and randomized bench for traffic_monitor, checked every cycle
// against a run-length reference model of the monitoring rules.
module tb_traffic_monitor;
  import traffic_pkg::*;

  localparam int GREEN_LEN  = 11;
  localparam int YELLOW_LEN = 4;
  localparam int PED_LEN    = 6;

  logic       clk;
  logic       reset_n;
  logic [2:0] lightA, lightB, lightC;
  logic       ped_signal, emergency, ped_req;
  logic [2:0] cur_phase;
  logic       err_valid;
  logic [2:0] err_code;
  logic       err_sticky;
  logic [7:0] green_cnt_a, green_cnt_b, green_cnt_c, ped_cnt, err_cnt;

  traffic_monitor #(
    .GREEN_LEN  (GREEN_LEN),
    .YELLOW_LEN (YELLOW_LEN),
    .PED_LEN    (PED_LEN)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .lightA      (lightA),
    .lightB      (lightB),
    .lightC      (lightC),
    .ped_signal  (ped_signal),
    .emergency   (emergency),
    .ped_req     (ped_req),
    .cur_phase   (cur_phase),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .err_sticky  (err_sticky),
    .green_cnt_a (green_cnt_a),
    .green_cnt_b (green_cnt_b),
    .green_cnt_c (green_cnt_c),
    .ped_cnt     (ped_cnt),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Reference model state: current run of identical valid samples.
  int m_ph;
  int m_run;
  bit m_fresh, m_first, m_emerg;
  bit prev_em, prev_pr;
  int exp_phase, exp_code;
  bit exp_valid, exp_sticky;
  int cnt_a, cnt_b, cnt_c, cnt_p, cnt_err;

  function automatic int nominal(input int p);
    if (p == 6) return PED_LEN;
    return (p % 2 == 0) ? GREEN_LEN : YELLOW_LEN;
  endfunction

  function automatic bit legal(input int p, input int q, input bit preq);
    if (p == 6) return q == 2;
    if (p % 2 == 0) return q == p + 1;
    return ((q == (p + 1) % 6) && !preq) || ((q == 6) && preq);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cur_phase", 8'(cur_phase), 8'(exp_phase));
    chk("err_valid", 8'(err_valid), 8'(exp_valid));
    if (exp_valid) chk("err_code", 8'(err_code), 8'(exp_code));
    chk("err_sticky", 8'(err_sticky), 8'(exp_sticky));
    chk("green_cnt_a", green_cnt_a, 8'(cnt_a));
    chk("green_cnt_b", green_cnt_b, 8'(cnt_b));
    chk("green_cnt_c", green_cnt_c, 8'(cnt_c));
    chk("ped_cnt", ped_cnt, 8'(cnt_p));
    chk("err_cnt", err_cnt, 8'(cnt_err));
  endtask

  task automatic model_reset();
    m_ph = -1; m_run = 0; m_fresh = 1; m_first = 0; m_emerg = 0;
    prev_em = 0; prev_pr = 0;
    exp_phase = 7; exp_code = 0; exp_valid = 0; exp_sticky = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_p = 0; cnt_err = 0;
  endtask

  task automatic model_sample(input logic [2:0] a, b, c, input bit ps, em, pr);
    int go, dcode, ph, code;
    bit oh;
    oh = ($countones(a) == 1) && ($countones(b) == 1) && ($countones(c) == 1);
    go = int'(a != 3'b100) + int'(b != 3'b100) + int'(c != 3'b100);
    dcode = 0;
    if (!oh) dcode = 1;
    else if (go > 1 || (ps && go > 0)) dcode = 2;
    else if (go == 0 && !ps) dcode = 5;
    ph = 6;
    if (a != 3'b100) ph = (a == 3'b001) ? 0 : 1;
    else if (b != 3'b100) ph = (b == 3'b001) ? 2 : 3;
    else if (c != 3'b100) ph = (c == 3'b001) ? 4 : 5;
    code = 0;
    if (dcode != 0) begin
      code = dcode;
      ph = 7;
      m_fresh = 1;
    end else if (m_fresh || ph != m_ph) begin
      if (!m_fresh) begin
        if (!(legal(m_ph, ph, prev_pr) || (ph == 0 && prev_em))) code = 3;
        else if (!m_first && !m_emerg && !em && m_run < 31 && m_run != nominal(m_ph)) code = 4;
      end
      m_first = m_fresh; m_fresh = 0; m_ph = ph; m_run = 1; m_emerg = em;
      if (ph == 0) cnt_a = (cnt_a + 1) % 256;
      if (ph == 2) cnt_b = (cnt_b + 1) % 256;
      if (ph == 4) cnt_c = (cnt_c + 1) % 256;
      if (ph == 6) cnt_p = (cnt_p + 1) % 256;
    end else begin
      m_run++;
      m_emerg = m_emerg || em;
      if (m_run == 31 && !m_first && !m_emerg) code = 4;
    end
    exp_phase = ph;
    exp_code  = code;
    exp_valid = (code != 0);
    if (code != 0) begin
      exp_sticky = 1;
      if (cnt_err < 255) cnt_err++;
    end
    prev_em = em;
    prev_pr = pr;
  endtask

  task automatic raw_step(input logic [2:0] a, b, c, input logic ps, em, pr);
    lightA = a; lightB = b; lightC = c;
    ped_signal = ps; emergency = em; ped_req = pr;
    @(posedge clk);
    model_sample(a, b, c, ps, em, pr);
    #1;
    check_all();
  endtask

  task automatic step(input int ph, input logic em, input logic pr);
    logic [2:0] la, lb, lc, shown;
    la = LIGHT_RED; lb = LIGHT_RED; lc = LIGHT_RED;
    shown = (ph % 2 == 0) ? LIGHT_GREEN : LIGHT_YELLOW;
    if (ph == 0 || ph == 1) la = shown;
    if (ph == 2 || ph == 3) lb = shown;
    if (ph == 4 || ph == 5) lc = shown;
    raw_step(la, lb, lc, ph == 6, em, pr);
  endtask

  task automatic run(input int ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ph;
    tests = 0;
    fails = 0;
    lightA = LIGHT_RED; lightB = LIGHT_RED; lightC = LIGHT_RED;
    ped_signal = 0; emergency = 0; ped_req = 0;
    model_reset();
    do_reset();
    chk("reset_cur_phase", 8'(cur_phase), 8'd7);
    chk("reset_err_cnt", err_cnt, 8'd0);

    // Compliant full cycle back to AG
    run(0, 11); run(1, 4); run(2, 11); run(3, 4); run(4, 11); run(5, 4); run(0, 1);
    chk("cycle_green_a", green_cnt_a, 8'd2);
    chk("cycle_green_b", green_cnt_b, 8'd1);
    chk("cycle_green_c", green_cnt_c, 8'd1);
    chk("cycle_err_cnt", err_cnt, 8'd0);

    // Pedestrian phase requested on the last AY sample
    run(0, 10); run(1, 3); step(1, 1'b0, 1'b1); run(6, 6); step(2, 1'b0, 1'b0);
    chk("ped_cnt", ped_cnt, 8'd1);
    chk("ped_no_err", 8'(err_valid), 8'd0);

    // Short BG
    run(2, 8); step(3, 1'b0, 1'b0);
    chk("short_bg_valid", 8'(err_valid), 8'd1);
    chk("short_bg_code", 8'(err_code), 8'd4);

    // Emergency cuts BG short
    run(3, 3); run(4, 11); run(5, 4); run(0, 11); run(1, 4); run(2, 4);
    step(2, 1'b1, 1'b0); step(0, 1'b0, 1'b0);
    chk("emerg_no_err", 8'(err_valid), 8'd0);
    chk("emerg_err_cnt", err_cnt, 8'd1);
    run(0, 3);

    // Two roads green at once
    do_reset();
    run(0, 3);
    raw_step(3'b001, 3'b001, 3'b100, 1'b0, 1'b0, 1'b0);
    chk("conflict_code", 8'(err_code), 8'd2);
    chk("conflict_sticky", 8'(err_sticky), 8'd1);
    chk("conflict_cnt", err_cnt, 8'd1);
    chk("conflict_phase", 8'(cur_phase), 8'd7);

    // Bad encoding, then mid-phase reset
    raw_step(3'b100, 3'b100, 3'b011, 1'b0, 1'b0, 1'b0);
    chk("enc_code", 8'(err_code), 8'd1);
    chk("enc_phase", 8'(cur_phase), 8'd7);
    run(0, 4);
    do_reset();
    chk("mid_reset_sticky", 8'(err_sticky), 8'd0);
    chk("mid_reset_cnt", err_cnt, 8'd0);
    run(0, 6);
    chk("resume_no_err", err_cnt, 8'd0);
    chk("resume_green_a", green_cnt_a, 8'd1);

    // Stuck BG reported once only
    run(1, 4); run(2, 35); step(3, 1'b0, 1'b0);
    chk("stuck_once", err_cnt, 8'd1);

    // Randomized phase runs
    do_reset();
    ph = 0;
    for (int r = 0; r < 300; r++) begin
      int len, nxt, sel;
      sel = $urandom_range(0, 99);
      if (sel < 70) len = nominal(ph);
      else if (sel < 95) len = $urandom_range(1, 14);
      else len = $urandom_range(31, 34);
      sel = $urandom_range(0, 99);
      if (sel < 75) begin
        if (ph == 6) nxt = 2;
        else if (ph % 2 == 0) nxt = ph + 1;
        else nxt = ($urandom_range(0, 2) == 0) ? 6 : (ph + 1) % 6;
      end else begin
        nxt = $urandom_range(0, 6);
      end
      for (int k = 0; k < len; k++) begin
        logic em, pr;
        em = ($urandom_range(0, 99) < 2);
        if (k == len - 1 && ph != 6 && ph % 2 == 1) pr = (nxt == 6) ^ ($urandom_range(0, 9) == 0);
        else pr = ($urandom_range(0, 9) == 0);
        sel = $urandom_range(0, 199);
        if (sel < 4) raw_step(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), em, pr);
        else if (sel == 4) do_reset();
        else step(ph, em, pr);
      end
      ph = nxt;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
